// File: rtl/seg_pkg.sv
// Shared constants, segment table and scan-state type for the seg_scan display controller.
package seg_pkg;

  localparam logic [7:0] SEG_BLANK  = 8'hFF;
  localparam logic [3:0] DIG_OFF    = 4'hF;
  localparam int         NUM_DIGITS = 4;

  // Active-low {dp, g..a} patterns for hex digits 0..F (dp bit is always off here).
  localparam logic [7:0] SEG_TABLE [0:15] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  typedef enum logic {BLANK, SHOW} scan_state_t;

  // True when digit k (1..3) and every digit to its left hold zero; upper is value[15:4].
  function automatic logic lzs_blank(input logic [11:0] upper, input logic [1:0] k);
    logic r;
    case (k)
      2'd3:    r = (upper[11:8] == 4'h0);
      2'd2:    r = (upper[11:4] == 8'h00);
      2'd1:    r = (upper == 12'h000);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/hex_seg_dec.sv
// Registered hex-to-7-segment decoder (active-low g..a), one clock of latency.
module hex_seg_dec
  import seg_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] hex,
  output logic [6:0] seg7
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg7 <= 7'h7F;
    end else begin
      seg7 <= SEG_TABLE[hex][6:0];
    end
  end

endmodule

// File: rtl/seg_scan.sv
// 4-digit multiplexed 7-segment scan controller with blanking gaps and frame-aligned updates.
// Optional leading-zero suppression is enabled by defining SEG_SCAN_LZS_EN.
module seg_scan
  import seg_pkg::*;
#(
  parameter int DWELL_CYCLES = 25000,
  parameter int BLANK_CYCLES = 250
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic [3:0]  dp,
  input  logic        load,
  output logic [7:0]  seg,
  output logic [3:0]  digit_sel,
  output logic        loaded,
  output logic        frame_start
);

  localparam int MAXC  = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W = (MAXC > 2) ? $clog2(MAXC) : 1;
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(DWELL_CYCLES - 1);

  scan_state_t      r_state;
  logic [1:0]       r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic [19:0]      r_pending;
  logic             r_pend_v;
  logic [19:0]      r_shadow;
  logic [7:0]       r_seg;
  logic [3:0]       r_digit_sel;
  logic             r_loaded;
  logic             r_frame_start;

  scan_state_t      w_state_n;
  logic [1:0]       w_idx_n;
  logic [CNT_W-1:0] w_cnt_n;
  logic             w_boundary;
  logic [3:0]       w_hex;
  logic [6:0]       w_seg7;
  logic [3:0]       w_dp;
  logic [7:0]       w_seg_n;
  logic [3:0]       w_dsel_n;

  assign w_dp  = r_shadow[19:16];
  assign w_hex = r_shadow[{r_idx, 2'b00} +: 4];

  hex_seg_dec u_dec (
    .clk   (clk),
    .rst_n (rst_n),
    .hex   (w_hex),
    .seg7  (w_seg7)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= BLANK;
      r_idx   <= 2'd0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_n;
      r_idx   <= w_idx_n;
      r_cnt   <= w_cnt_n;
    end
  end

  always_comb begin
    w_state_n  = r_state;
    w_idx_n    = r_idx;
    w_cnt_n    = r_cnt + 1'b1;
    w_boundary = 1'b0;
    case (r_state)
      BLANK: begin
        if (r_cnt == BLANK_LAST) begin
          w_state_n = SHOW;
          w_cnt_n   = '0;
        end
      end
      SHOW: begin
        if (r_cnt == SHOW_LAST) begin
          w_state_n  = BLANK;
          w_idx_n    = r_idx + 2'd1;
          w_cnt_n    = '0;
          w_boundary = (r_idx == 2'd3);
        end
      end
      default: begin
        w_state_n = BLANK;
        w_cnt_n   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so digit_sel and seg switch on the same edge.
  always_comb begin
    w_seg_n  = SEG_BLANK;
    w_dsel_n = DIG_OFF;
    if (w_state_n == SHOW) begin
      w_dsel_n = ~(4'b0001 << w_idx_n);
      w_seg_n  = {~w_dp[w_idx_n], w_seg7};
`ifdef SEG_SCAN_LZS_EN
      if (lzs_blank(r_shadow[15:4], w_idx_n)) begin
        w_seg_n[6:0] = 7'h7F;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg         <= SEG_BLANK;
      r_digit_sel   <= DIG_OFF;
      r_loaded      <= 1'b0;
      r_frame_start <= 1'b0;
      r_pending     <= '0;
      r_pend_v      <= 1'b0;
      r_shadow      <= '0;
    end else begin
      r_seg         <= w_seg_n;
      r_digit_sel   <= w_dsel_n;
      r_frame_start <= w_boundary;
      r_loaded      <= 1'b0;
      if (w_boundary && load) begin
        // A load landing on the boundary bypasses pending entirely.
        r_shadow  <= {dp, value};
        r_pending <= {dp, value};
        r_pend_v  <= 1'b0;
        r_loaded  <= 1'b1;
      end else begin
        if (w_boundary && r_pend_v) begin
          r_shadow <= r_pending;
          r_pend_v <= 1'b0;
          r_loaded <= 1'b1;
        end
        if (load) begin
          r_pending <= {dp, value};
          r_pend_v  <= 1'b1;
        end
      end
    end
  end

  assign seg         = r_seg;
  assign digit_sel   = r_digit_sel;
  assign loaded      = r_loaded;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan with a 40-clock frame (DWELL=8, BLANK=2).
module tb_seg_scan;

  localparam int DW = 8;
  localparam int BW = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp = '0;
  logic        load = 1'b0;
  logic [7:0]  seg;
  logic [3:0]  digit_sel;
  logic        loaded;
  logic        frame_start;

  seg_scan #(.DWELL_CYCLES(DW), .BLANK_CYCLES(BW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .value       (value),
    .dp          (dp),
    .load        (load),
    .seg         (seg),
    .digit_sel   (digit_sel),
    .loaded      (loaded),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0]     value;
    logic [3:0]      dp;
    logic [3:0][7:0] exp;   // exp[k] = seg for digit k
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];
  logic [3:0] dsel_exp [4];

  int n_vec = 0;
  int n_err = 0;
  int pos = 0;
  int n_loaded = 0;
  int n0;

  always @(negedge clk) if (loaded === 1'b1) n_loaded++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic goto(input int p);
    tick(p - pos);
    pos = p;
  endtask

  task automatic wait_frame();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge clk);
      #1;
      if (frame_start === 1'b1) got = 1'b1;
    end
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL frame_start_timeout: got none, expected pulse within 100 clocks");
    end
    pos = 0;
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp    = d;
    load  = 1'b1;
    tick(1);
    pos++;
    load  = 1'b0;
  endtask

  task automatic check_frame(input logic [3:0][7:0] exp, input string tag);
    goto(1);
    chk({tag, " blank dsel"}, 32'(digit_sel), 32'h0F);
    chk({tag, " blank seg"}, 32'(seg), 32'hFF);
    for (int k = 0; k < 4; k++) begin
      goto(2 + 10 * k);
      chk($sformatf("%s d%0d dsel", tag, k), 32'(digit_sel), 32'(dsel_exp[k]));
      chk($sformatf("%s d%0d seg start", tag, k), 32'(seg), 32'(exp[k]));
      goto(9 + 10 * k);
      chk($sformatf("%s d%0d seg end", tag, k), 32'(seg), 32'(exp[k]));
    end
  endtask

  initial begin
    dsel_exp[0] = 4'hE; dsel_exp[1] = 4'hD; dsel_exp[2] = 4'hB; dsel_exp[3] = 4'h7;
    vecs[0] = '{16'h12AF, 4'b0000, {8'hF9, 8'hA4, 8'h88, 8'h8E}};
    vecs[3] = '{16'h89C5, 4'b1010, {8'h00, 8'h90, 8'h46, 8'h92}};
    vecs[4] = '{16'h4DE6, 4'b0001, {8'h99, 8'hA1, 8'h86, 8'h02}};
`ifdef SEG_SCAN_LZS_EN
    vecs[1] = '{16'h0000, 4'b0100, {8'hFF, 8'h7F, 8'hFF, 8'hC0}};
    vecs[2] = '{16'h0007, 4'b0000, {8'hFF, 8'hFF, 8'hFF, 8'hF8}};
    vecs[5] = '{16'h0B00, 4'b0000, {8'hFF, 8'h83, 8'hC0, 8'hC0}};
    vecs[6] = '{16'h0010, 4'b1000, {8'h7F, 8'hFF, 8'hF9, 8'hC0}};
`else
    vecs[1] = '{16'h0000, 4'b0100, {8'hC0, 8'h40, 8'hC0, 8'hC0}};
    vecs[2] = '{16'h0007, 4'b0000, {8'hC0, 8'hC0, 8'hC0, 8'hF8}};
    vecs[5] = '{16'h0B00, 4'b0000, {8'hC0, 8'h83, 8'hC0, 8'hC0}};
    vecs[6] = '{16'h0010, 4'b1000, {8'h40, 8'hC0, 8'hF9, 8'hC0}};
`endif

    // Reset state and first scan after release
    #23;
    chk("rst seg", 32'(seg), 32'hFF);
    chk("rst dsel", 32'(digit_sel), 32'h0F);
    chk("rst loaded", 32'(loaded), 32'h0);
    chk("rst frame_start", 32'(frame_start), 32'h0);
    @(posedge clk);
    #4;
    rst_n = 1'b1;
    pos = 0;
    goto(1);
    chk("exit dsel c1", 32'(digit_sel), 32'h0F);
    chk("exit no frame_start", 32'(frame_start), 32'h0);
    goto(2);
    chk("exit dsel c2", 32'(digit_sel), 32'h0E);
    chk("exit seg c2", 32'(seg), 32'hC0);
    goto(9);
    chk("exit dsel c9", 32'(digit_sel), 32'h0E);
    goto(10);
    chk("exit dsel c10", 32'(digit_sel), 32'h0F);
    goto(11);
    chk("exit dsel c11", 32'(digit_sel), 32'h0F);
    goto(12);
    chk("exit dsel c12", 32'(digit_sel), 32'h0D);

    // Table-driven decode vectors
    for (int i = 0; i < NV; i++) begin
      wait_frame();
      goto(5);
      do_load(vecs[i].value, vecs[i].dp);
      wait_frame();
      chk($sformatf("vec%0d loaded", i), 32'(loaded), 32'h1);
      check_frame(vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Mid-frame load: rest of frame keeps old digits, one loaded pulse
    wait_frame();
    wait_frame();
    n0 = n_loaded;
    goto(15);
    do_load(16'h3333, 4'b0000);
    goto(26);
    chk("mid old d2", 32'(seg), 32'(vecs[NV-1].exp[2]));
    goto(36);
    chk("mid old d3", 32'(seg), 32'(vecs[NV-1].exp[3]));
    chk("mid no early loaded", 32'(n_loaded - n0), 32'h0);
    wait_frame();
    chk("mid loaded", 32'(loaded), 32'h1);
    check_frame({8'hB0, 8'hB0, 8'hB0, 8'hB0}, "mid");
    wait_frame();
    chk("mid loaded count", 32'(n_loaded - n0), 32'h1);

    // Load on the boundary clock
    wait_frame();
    goto(39);
    do_load(16'hA5C3, 4'b0000);
    chk("bnd frame_start", 32'(frame_start), 32'h1);
    chk("bnd loaded", 32'(loaded), 32'h1);
    pos = 0;
    check_frame({8'h88, 8'h92, 8'hC6, 8'hB0}, "bnd");
    wait_frame();
    chk("bnd pend cleared", 32'(loaded), 32'h0);

    // Two loads in one frame: last wins
    wait_frame();
    n0 = n_loaded;
    goto(5);
    do_load(16'h1111, 4'b0000);
    goto(20);
    do_load(16'h6789, 4'b0000);
    wait_frame();
    chk("two loaded", 32'(loaded), 32'h1);
    check_frame({8'h82, 8'hF8, 8'h80, 8'h90}, "two");
    wait_frame();
    chk("two loaded count", 32'(n_loaded - n0), 32'h1);

    // Asynchronous reset mid-SHOW
    wait_frame();
    goto(6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async dsel", 32'(digit_sel), 32'h0F);
    chk("async seg", 32'(seg), 32'hFF);
    rst_n = 1'b1;
    pos = 0;
    goto(2);
    chk("async exit dsel", 32'(digit_sel), 32'h0E);
    chk("async exit seg", 32'(seg), 32'hC0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
